lb_frame_sequencer: RTL and testbench
=====================================

Name: lb_frame_sequencer

Overview:
Frame-level controller for the padded 3x3 line-buffer window generator.
- Accepts one frame of channel-parallel pixels from an upstream valid/ready stream.
- Drives the line buffer's push strobe and data, then injects zero flush beats so the last image row drains out.
- Counts emitted windows and signals frame completion or a drain timeout to the layer scheduler.

Parameters:
NUM_CHANNELS, 8, channels per pixel beat
DATA_WIDTH, 8, bits per channel sample
IMG_WIDTH, 256, pixels per row
IMG_HEIGHT, 256, rows per frame
FLUSH_EXTRA, 2, zero beats pushed after one full flush row (covers line-buffer alignment registers)
DRAIN_TIMEOUT, 1024, idle cycles allowed in DRAIN before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  frame start pulse; honoured only in IDLE
i_abort  in  1  abandon current frame; returns to IDLE next cycle
s_valid  in  1  upstream pixel valid
s_ready  out  1  upstream ready; combinational: (state==FILL) && m_ready
s_data  in  NUM_CHANNELS*DATA_WIDTH  upstream pixel beat
m_ready  in  1  downstream window consumer can absorb further pushes
lb_valid  out  1  registered push strobe to the line buffer
lb_data  out  NUM_CHANNELS*DATA_WIDTH  registered push data
win_valid  in  1  window-valid strobe returned from the line buffer
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse on frame completion
o_error  out  1  sticky drain-timeout flag; cleared by rst or i_start
o_win_cnt  out  clog2(W*H+1)  windows counted in the current frame

Behaviour:
- Reset: state IDLE; every output 0 (lb_data 0, o_win_cnt 0). Reset mid-frame aborts immediately; no done pulse.
- States:
  - IDLE: i_start moves to FILL and clears pix_cnt, flush_cnt, win_cnt, timeout counter and o_error.
  - FILL: a beat is accepted when s_valid && s_ready. On the next cycle lb_valid=1 and lb_data=s_data (1-cycle latency); otherwise lb_valid=0 and lb_data holds. After beat W*H-1 is accepted, go to FLUSH.
  - FLUSH: each cycle with m_ready=1 pushes lb_valid=1 with lb_data=0 and increments flush_cnt. After IMG_WIDTH+FLUSH_EXTRA pushes, go to DRAIN.
  - DRAIN: no pushes. The timeout counter increments each cycle and resets to 0 on any win_valid.
    - When win_cnt reaches W*H, go to DONE.
    - When the counter reaches DRAIN_TIMEOUT, set o_error and go to DONE.
  - DONE: o_done=1 for exactly this cycle, then IDLE.
- m_ready=0 stalls both FILL acceptance and FLUSH pushes. No beat is lost or duplicated.
- The downstream consumer is required to absorb windows in flight after m_ready falls. Line-buffer output latency is at most 3 pushes.
- win_valid increments win_cnt in every non-IDLE state, saturating at W*H. Extra windows after saturation are ignored.
- i_abort in any non-IDLE state: next state IDLE, no o_done, counters frozen until the next i_start. A final beat accepted the same cycle is still pushed.
- i_start outside IDLE is ignored. i_abort takes priority over a state's exit condition in the same cycle.
- Simultaneous win_valid and the exit condition: the count update takes effect first, and the transition uses the updated count.
- Counter widths come from clog2. Comparisons are unsigned, and there is no wrap inside a frame.

Decomposition:
- Shared package lb_pkg:
  - state enum (IDLE, FILL, FLUSH, DRAIN, DONE)
  - PIX_BEATS = IMG_WIDTH*IMG_HEIGHT
  - FLUSH_BEATS = IMG_WIDTH+FLUSH_EXTRA
  - counter width constants
- One natural sub-module: lb_beat_counter, a parameterised up-counter with clear, enable and terminal-count flag. It is instantiated for pix_cnt, flush_cnt and the timeout counter.
- The FSM and push register stay in the top module.

Test Plan:
- W=4, H=3, FLUSH_EXTRA=2; i_start, then 12 continuous beats (values 1..12) with m_ready=1. Expect 12 lb_valid pushes carrying 1..12, then 6 zero pushes. After 12 win_valid, o_done pulses once, o_error=0 and o_win_cnt=12.
- Same setup; drop m_ready for 3 cycles after beat 5 and again during FLUSH. Expect s_ready=0 and no lb_valid while m_ready is low; the push sequence stays exactly 1..12 then 6 zeros.
- W=4, H=3, DRAIN_TIMEOUT=8; return only 10 win_valid. Expect o_error=1 exactly 8 cycles after the last win_valid, o_done pulses once, and o_error stays set in IDLE until the next i_start.
- Assert i_abort after beat 7. Expect IDLE next cycle, s_ready=0, no o_done, and no further lb_valid beyond the push of beat 7.
- Pulse i_start during FILL: ignored, pix_cnt unaffected. Assert rst during FLUSH: all outputs 0 the next cycle. A new frame then completes normally with o_win_cnt=12.
- win_valid coincides with reaching the 12th window: o_done is asserted the following cycle, and the count is not double-counted.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared types and sizing helpers for the padded 3x3 line-buffer frame sequencer.
package lb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } lb_state_t;

  localparam int unsigned DEF_IMG_WIDTH     = 256;
  localparam int unsigned DEF_IMG_HEIGHT    = 256;
  localparam int unsigned DEF_FLUSH_EXTRA   = 2;
  localparam int unsigned DEF_DRAIN_TIMEOUT = 1024;

  localparam int unsigned PIX_BEATS   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  localparam int unsigned FLUSH_BEATS = DEF_IMG_WIDTH + DEF_FLUSH_EXTRA;

  function automatic int unsigned pix_beats(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  function automatic int unsigned flush_beats(input int unsigned w, input int unsigned extra);
    return w + extra;
  endfunction

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lb_beat_counter.sv
// Up-counter with synchronous clear/enable; 'last' flags that the next enabled step reaches TERMINAL.
module lb_beat_counter
  import lb_pkg::*;
#(
  parameter int unsigned TERMINAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned WIDTH = cnt_width(TERMINAL);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == WIDTH'(TERMINAL - 1));

endmodule

// File: rtl/lb_frame_sequencer.sv
// Frame controller: feeds one frame into the line buffer, flushes the last row, then waits for all windows.
module lb_frame_sequencer
  import lb_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned IMG_WIDTH     = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT    = DEF_IMG_HEIGHT,
  parameter int unsigned FLUSH_EXTRA   = DEF_FLUSH_EXTRA,
  parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_start,
  input  logic                                       i_abort,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]         s_data,
  input  logic                                       m_ready,
  output logic                                       lb_valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]         lb_data,
  input  logic                                       win_valid,
  output logic                                       o_busy,
  output logic                                       o_done,
  output logic                                       o_error,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0]  o_win_cnt
);

  localparam int unsigned PIX     = pix_beats(IMG_WIDTH, IMG_HEIGHT);
  localparam int unsigned FLUSH_N = flush_beats(IMG_WIDTH, FLUSH_EXTRA);
  localparam int unsigned WIN_W   = cnt_width(PIX);

  lb_state_t        state, state_next;
  logic             start, accept, push_flush;
  logic             pix_last, flush_last, to_last, to_clr, to_fire, frame_done;
  logic [WIN_W-1:0] win_cnt, win_cnt_next;

  assign start      = (state == ST_IDLE) && i_start;
  assign s_ready    = (state == ST_FILL) && m_ready;
  assign accept     = s_valid && s_ready;
  assign push_flush = (state == ST_FLUSH) && m_ready;
  assign to_clr     = start || (win_valid && (state != ST_IDLE));

  lb_beat_counter #(.TERMINAL(PIX)) u_pix_cnt (
    .clk (clk), .rst (rst), .clr (start), .en (accept), .last (pix_last)
  );

  lb_beat_counter #(.TERMINAL(FLUSH_N)) u_flush_cnt (
    .clk (clk), .rst (rst), .clr (start), .en (push_flush), .last (flush_last)
  );

  lb_beat_counter #(.TERMINAL(DRAIN_TIMEOUT)) u_timeout_cnt (
    .clk (clk), .rst (rst), .clr (to_clr), .en (state == ST_DRAIN), .last (to_last)
  );

  // Saturating window count; the DRAIN exit decision looks at the post-update value.
  always_comb begin
    win_cnt_next = win_cnt;
    if ((state != ST_IDLE) && win_valid && (win_cnt != WIN_W'(PIX))) begin
      win_cnt_next = win_cnt + 1'b1;
    end
  end

  assign frame_done = (win_cnt_next == WIN_W'(PIX));
  assign to_fire    = (state == ST_DRAIN) && !win_valid && to_last && !frame_done;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start) state_next = ST_FILL;
      ST_FILL:  if (accept && pix_last) state_next = ST_FLUSH;
      ST_FLUSH: if (push_flush && flush_last) state_next = ST_DRAIN;
      ST_DRAIN: if (frame_done || to_fire) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if ((state != ST_IDLE) && i_abort) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lb_valid <= 1'b0;
      lb_data  <= '0;
      win_cnt  <= '0;
      o_error  <= 1'b0;
    end else begin
      state    <= state_next;
      lb_valid <= accept || push_flush;
      if (accept) begin
        lb_data <= s_data;
      end else if (push_flush) begin
        lb_data <= '0;
      end
      win_cnt <= start ? '0 : win_cnt_next;
      if (start) begin
        o_error <= 1'b0;
      end else if (to_fire && !i_abort) begin
        o_error <= 1'b1;
      end
    end
  end

  assign o_busy    = (state != ST_IDLE);
  assign o_done    = (state == ST_DONE);
  assign o_win_cnt = win_cnt;

endmodule

// File: tb/tb_lb_frame_sequencer.sv
// Self-checking bench for lb_frame_sequencer on a 4x3 frame with an 8-cycle drain timeout.
module tb_lb_frame_sequencer;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int FX   = 2;
  localparam int TO   = 8;
  localparam int N    = W * H;
  localparam int NP   = N + W + FX;
  localparam int DW   = 64;
  localparam int CW   = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst, i_start, i_abort, s_valid, m_ready, win_valid;
  logic [DW-1:0] s_data;
  logic          s_ready, lb_valid, o_busy, o_done, o_error;
  logic [DW-1:0] lb_data;
  logic [CW-1:0] o_win_cnt;

  lb_frame_sequencer #(
    .NUM_CHANNELS (8),
    .DATA_WIDTH   (8),
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .FLUSH_EXTRA  (FX),
    .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_ready   (m_ready),
    .lb_valid  (lb_valid),
    .lb_data   (lb_data),
    .win_valid (win_valid),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_error   (o_error),
    .o_win_cnt (o_win_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] pushes[$];
  int            done_cnt   = 0;
  int            stall_viol = 0;
  logic          mr_q       = 1'b1;

  always @(posedge clk) mr_q <= m_ready;

  always @(negedge clk) begin
    if (lb_valid === 1'b1) begin
      pushes.push_back(lb_data);
      if (!mr_q) stall_viol++;
    end
    if (o_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int stall_after;
    int stall_len;
    bit flush_stall;
    bit gappy;
    bit rand_data;
    int wins;
    bit exp_err;
    int exp_cnt;
  } frame_vec_t;

  // Reference model for one frame: every beat once in order, then W+FX zero pushes,
  // window count saturating at W*H, and a timeout TO edges after the last window.
  task automatic run_frame(input frame_vec_t v);
    logic [DW-1:0] beats[N];
    int idx, stall_left, cyc, done_n, err_n;
    bit fl_done, acc;
    for (int i = 0; i < N; i++) beats[i] = v.rand_data ? {$urandom, $urandom} : DW'(i + 1);
    pushes.delete();
    done_cnt = 0;
    stall_viol = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_clears_error", o_error, 0);
    chk("start_busy", o_busy, 1);
    idx = 0; stall_left = 0; cyc = 0; fl_done = 0;
    while (pushes.size() < NP && cyc < 400) begin
      m_ready = 1'b1;
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (v.flush_stall && !fl_done && pushes.size() >= N + 2) begin
        m_ready = 1'b0;
        stall_left = 2;
        fl_done = 1;
      end
      s_valid = (idx < N) && (!v.gappy || $urandom_range(0, 2) != 0);
      s_data  = (idx < N) ? beats[idx] : '0;
      #1;
      if (!m_ready && s_ready) stall_viol++;
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx == v.stall_after) stall_left = v.stall_len;
      end
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int w = 0; w < v.wins; w++) begin
      win_valid = 1'b1;
      tick();
      win_valid = 1'b0;
      if (w < v.wins - 1) repeat ($urandom_range(0, 2)) tick();
    end
    done_n = -1;
    err_n  = -1;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) tick();
      if (o_done && done_n < 0) done_n = n;
      if (o_error && err_n < 0) err_n = n;
    end
    chk("push_count", pushes.size(), NP);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("push_%0d", i), (i < pushes.size()) ? pushes[i] : 64'hdead,
          (i < N) ? beats[i] : 64'h0);
    end
    chk("no_push_when_stalled", stall_viol, 0);
    chk("done_pulses", done_cnt, 1);
    chk("done_timing", done_n, v.exp_err ? TO : 0);
    chk("error_timing", err_n, v.exp_err ? TO : -1);
    chk("error_sticky_idle", o_error, v.exp_err);
    chk("win_cnt", o_win_cnt, v.exp_cnt);
    chk("idle_after_frame", o_busy, 0);
  endtask

  frame_vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_start = 0; i_abort = 0; s_valid = 0; m_ready = 1; win_valid = 0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lb_valid", lb_valid, 0);
    chk("rst_lb_data", lb_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_win_cnt", o_win_cnt, 0);
    chk("rst_s_ready", s_ready, 0);
    rst = 1'b0;
    tick();

    vecs[0] = '{stall_after: 0, stall_len: 0, flush_stall: 0, gappy: 0, rand_data: 0,
                wins: 12, exp_err: 0, exp_cnt: 12};
    vecs[1] = '{stall_after: 5, stall_len: 3, flush_stall: 1, gappy: 0, rand_data: 0,
                wins: 12, exp_err: 0, exp_cnt: 12};
    vecs[2] = '{stall_after: 0, stall_len: 0, flush_stall: 0, gappy: 0, rand_data: 0,
                wins: 10, exp_err: 1, exp_cnt: 10};
    for (int r = 3; r < 7; r++) begin
      vecs[r].stall_after = $urandom_range(1, N - 1);
      vecs[r].stall_len   = $urandom_range(1, 4);
      vecs[r].flush_stall = 1'($urandom_range(0, 1));
      vecs[r].gappy       = 1'b1;
      vecs[r].rand_data   = 1'b1;
      vecs[r].wins        = $urandom_range(10, N);
      vecs[r].exp_err     = (vecs[r].wins < N);
      vecs[r].exp_cnt     = vecs[r].wins;
    end
    for (int r = 0; r < 7; r++) run_frame(vecs[r]);

    // Abort coinciding with the acceptance of beat 7.
    pushes.delete();
    done_cnt = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int b = 1; b <= 7; b++) begin
      s_valid = 1'b1;
      s_data  = DW'(b);
      i_abort = (b == 7);
      tick();
    end
    i_abort = 1'b0;
    chk("abort_idle", o_busy, 0);
    chk("abort_s_ready", s_ready, 0);
    s_data = DW'(99);
    repeat (6) tick();
    s_valid = 1'b0;
    chk("abort_push_cnt", pushes.size(), 7);
    chk("abort_last_push", (pushes.size() >= 7) ? pushes[6] : 64'hdead, 7);
    chk("abort_no_done", done_cnt, 0);

    // Stray i_start during FILL, then reset in the middle of FLUSH.
    pushes.delete();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int b = 1; b <= N; b++) begin
      s_valid   = 1'b1;
      s_data    = DW'(b);
      i_start   = (b == 3);
      win_valid = (b <= 2);
      tick();
    end
    i_start = 1'b0;
    win_valid = 1'b0;
    s_data = DW'(77);
    chk("fill_start_ignored", s_ready, 0);
    s_valid = 1'b0;
    tick();
    tick();
    chk("win_cnt_in_fill", o_win_cnt, 2);
    chk("pushes_before_rst", pushes.size(), N + 1);
    chk("last_pix_push", (pushes.size() >= N) ? pushes[N-1] : 64'hdead, N);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_lb_valid", lb_valid, 0);
    chk("midrst_lb_data", lb_data, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    chk("midrst_win_cnt", o_win_cnt, 0);
    run_frame(vecs[0]);

    // Final window lands on the saturating edge, with win_valid held through DONE and IDLE.
    pushes.delete();
    done_cnt = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int b = 1; b <= N; b++) begin
      s_valid = 1'b1;
      s_data  = DW'(b + 100);
      tick();
    end
    s_valid = 1'b0;
    for (int c = 0; c < 40 && pushes.size() < NP; c++) tick();
    chk("sat_push_cnt", pushes.size(), NP);
    for (int w = 0; w < N - 1; w++) begin
      win_valid = 1'b1;
      tick();
      win_valid = 1'b0;
      tick();
    end
    chk("sat_pre_cnt", o_win_cnt, N - 1);
    win_valid = 1'b1;
    tick();
    chk("sat_done_next", o_done, 1);
    chk("sat_cnt_at_done", o_win_cnt, N);
    tick();
    chk("sat_done_once", o_done, 0);
    chk("sat_cnt_held", o_win_cnt, N);
    chk("sat_idle", o_busy, 0);
    tick();
    win_valid = 1'b0;
    chk("sat_cnt_idle", o_win_cnt, N);
    chk("sat_done_cnt", done_cnt, 1);
    chk("sat_no_error", o_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
